alu_rr_arbiter: RTL and testbench

- Shares one ALU instance between NUM_REQ requesters (e.g. execute stage, branch-compare unit, address generator) using round-robin arbitration.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Results are registered, so the block adds one cycle of latency.
- Sits between the requesting pipeline units and the single combinational ALU datapath.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 31 +++
 rtl/rr_pick.sv | 29 ++
 rtl/alu_rr_arbiter.sv | 108 ++++++++++
 tb/tb_alu_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct3 operation codes and result-slot state encoding.
package alu_pkg;

    // funct3 operation select codes
    localparam logic [2:0] ADD               = 3'b000;
    localparam logic [2:0] SHIFT_LEFT        = 3'b001;
    localparam logic [2:0] SET_LESS          = 3'b010;
    localparam logic [2:0] SET_LESS_UNSIGNED = 3'b011;
    localparam logic [2:0] XOR               = 3'b100;
    localparam logic [2:0] SHIFT_RIGHT       = 3'b101;
    localparam logic [2:0] OR                = 3'b110;
    localparam logic [2:0] AND               = 3'b111;

    // Result slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational 32-bit ALU selected by funct3.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] in_data1,
    input  logic [31:0] in_data2,
    input  logic [2:0]  in_select,
    output logic [31:0] out_result
);

    // Shift amounts of 32 or more push every bit out, so the result is zero.
    logic big_shift;
    assign big_shift = |in_data2[31:5];

    // Operation decode; all arithmetic wraps mod 2^32.
    always_comb begin
        out_result = 32'd0;
        case (in_select)
            ADD:               out_result = in_data1 + in_data2;
            SHIFT_LEFT:        out_result = big_shift ? 32'd0 : (in_data1 << in_data2[4:0]);
            SET_LESS:          out_result = {31'd0, ($signed(in_data1) < $signed(in_data2))};
            SET_LESS_UNSIGNED: out_result = {31'd0, (in_data1 < in_data2)};
            XOR:               out_result = in_data1 ^ in_data2;
            SHIFT_RIGHT:       out_result = big_shift ? 32'd0 : (in_data1 >> in_data2[4:0]);
            OR:                out_result = in_data1 | in_data2;
            AND:               out_result = in_data1 & in_data2;
            default:           out_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    // Scan ptr, ptr+1, ... wrapping at N; the first hit is latched via any_o.
    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters; the result is
// held in a one-entry registered slot owned by the granted requester.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      in_req_valid,
    output logic [NUM_REQ-1:0]      out_req_ready,
    input  logic [NUM_REQ*32-1:0]   in_req_data1,
    input  logic [NUM_REQ*32-1:0]   in_req_data2,
    input  logic [NUM_REQ*3-1:0]    in_req_select,
    output logic [NUM_REQ-1:0]      out_resp_valid,
    output logic [31:0]             out_resp_data,
    input  logic [NUM_REQ-1:0]      in_resp_ready,
    output logic                    out_busy
);

    slot_state_e          state_q;
    logic [IDX_W-1:0]     own_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [31:0]          data_q;
    logic [NUM_REQ-1:0]   valid_q;

    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any_gnt;
    logic                 free;
    logic                 accept;
    logic                 consume;
    logic [IDX_W-1:0]     ptr_d;

    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [2:0]           alu_sel;
    logic [31:0]          alu_res;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i     (in_req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_gnt)
    );

    // The owner draining its result this cycle frees the slot for a new accept,
    // giving one operation per cycle back-to-back. Non-owner ready bits are ignored.
    assign consume       = (state_q == FULL) && in_resp_ready[own_q];
    assign free          = (state_q == EMPTY) || consume;
    assign out_req_ready = (free && !reset) ? gnt : '0;
    assign accept        = free && any_gnt && !reset;

    // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
    assign ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (gnt_idx + 1'b1);

    // Route the granted requester's operands into the single ALU.
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_sel = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_a   = in_req_data1[32*i +: 32];
                alu_b   = in_req_data2[32*i +: 32];
                alu_sel = in_req_select[3*i +: 3];
            end
        end
    end

    alu u_alu (
        .in_data1   (alu_a),
        .in_data2   (alu_b),
        .in_select  (alu_sel),
        .out_result (alu_res)
    );

    // Slot FSM: accept loads a new result (even while draining the old one),
    // otherwise an owner consume empties the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            own_q   <= '0;
            ptr_q   <= '0;
            data_q  <= 32'd0;
            valid_q <= '0;
        end else if (accept) begin
            state_q <= FULL;
            own_q   <= gnt_idx;
            ptr_q   <= ptr_d;
            data_q  <= alu_res;
            valid_q <= gnt;
        end else if (consume) begin
            state_q <= EMPTY;
            valid_q <= '0;
        end
    end

    assign out_resp_valid = valid_q;
    assign out_resp_data  = data_q;
    assign out_busy       = (state_q == FULL);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed testbench for alu_rr_arbiter with NUM_REQ=2.
module tb_alu_rr_arbiter;

    localparam int N = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    in_req_valid;
    logic [N-1:0]    out_req_ready;
    logic [N*32-1:0] in_req_data1;
    logic [N*32-1:0] in_req_data2;
    logic [N*3-1:0]  in_req_select;
    logic [N-1:0]    out_resp_valid;
    logic [31:0]     out_resp_data;
    logic [N-1:0]    in_resp_ready;
    logic            out_busy;

    int checks = 0;
    int errors = 0;

    alu_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .out_req_ready  (out_req_ready),
        .in_req_data1   (in_req_data1),
        .in_req_data2   (in_req_data2),
        .in_req_select  (in_req_select),
        .out_resp_valid (out_resp_valid),
        .out_resp_data  (out_resp_data),
        .in_resp_ready  (in_resp_ready),
        .out_busy       (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (registered outputs settle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle point for combinational ready checks.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s);
        in_req_data1[32*i +: 32] = a;
        in_req_data2[32*i +: 32] = b;
        in_req_select[3*i +: 3]  = s;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_req_valid  = '0;
        in_resp_ready = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        in_req_valid  = 2'b11;
        in_resp_ready = '0;
        in_req_data1  = '0;
        in_req_data2  = '0;
        in_req_select = '0;
        tick();
        tick();
        mid();
        checks++; if (out_req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", out_req_ready); end
        checks++; if (out_resp_valid !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b exp 00", out_resp_valid); end
        checks++; if (out_resp_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_resp_data); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", out_busy); end
        tick();
        reset        = 1'b0;
        in_req_valid = '0;
    endtask

    task automatic test_single();
        set_req(0, 32'd5, 32'd7, 3'b000);
        in_req_valid  = 2'b01;
        in_resp_ready = 2'b00;
        mid();
        checks++; if (out_req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", out_req_ready); end
        tick();
        in_req_valid = 2'b00;
        checks++; if (out_resp_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b exp 01", out_resp_valid); end
        checks++; if (out_resp_data !== 32'd12) begin errors++; $display("FAIL single_data: got %h exp 0000000c", out_resp_data); end
        checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", out_busy); end
        in_resp_ready = 2'b01;
        tick();
        checks++; if (out_resp_valid !== 2'b00) begin errors++; $display("FAIL single_drain_valid: got %b exp 00", out_resp_valid); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL single_drain_busy: got %b exp 0", out_busy); end
        in_resp_ready = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [31:0]  ed;
        do_reset();
        set_req(0, 32'd3, 32'd1, 3'b001);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b000);
        in_req_valid  = 2'b11;
        in_resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            ed = (k % 2 == 0) ? 32'd6 : 32'd0;
            mid();
            checks++; if (out_req_ready !== eg) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, out_req_ready, eg); end
            tick();
            checks++; if (out_resp_valid !== eg) begin errors++; $display("FAIL rr_valid%0d: got %b exp %b", k, out_resp_valid, eg); end
            checks++; if (out_resp_data !== ed) begin errors++; $display("FAIL rr_data%0d: got %h exp %h", k, out_resp_data, ed); end
        end
        in_req_valid = 2'b00;
        tick();
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b exp 0", out_busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(1, 32'h8000_0000, 32'd1, 3'b010);
        in_req_valid  = 2'b10;
        in_resp_ready = 2'b00;
        mid();
        checks++; if (out_req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1: got %b exp 10", out_req_ready); end
        tick();
        set_req(0, 32'd9, 32'd4, 3'b100);
        in_req_valid = 2'b01;
        checks++; if (out_resp_data !== 32'd1) begin errors++; $display("FAIL bp_slt: got %h exp 1", out_resp_data); end
        for (int k = 0; k < 4; k++) begin
            mid();
            checks++; if (out_req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready%0d: got %b exp 00", k, out_req_ready); end
            tick();
            checks++; if (out_resp_data !== 32'd1) begin errors++; $display("FAIL bp_hold_data%0d: got %h exp 1", k, out_resp_data); end
            checks++; if (out_resp_valid !== 2'b10) begin errors++; $display("FAIL bp_hold_valid%0d: got %b exp 10", k, out_resp_valid); end
        end
        in_resp_ready = 2'b10;
        mid();
        checks++; if (out_req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_grant: got %b exp 01", out_req_ready); end
        tick();
        in_req_valid = 2'b00;
        checks++; if (out_resp_valid !== 2'b01) begin errors++; $display("FAIL bp_new_valid: got %b exp 01", out_resp_valid); end
        checks++; if (out_resp_data !== 32'd13) begin errors++; $display("FAIL bp_new_data: got %h exp 0000000d", out_resp_data); end
        in_resp_ready = 2'b01;
        tick();
        in_resp_ready = 2'b00;
    endtask

    task automatic test_compare_wrap();
        do_reset();
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        in_req_valid  = 2'b10;
        in_resp_ready = 2'b11;
        mid();
        checks++; if (out_req_ready !== 2'b10) begin errors++; $display("FAIL cmp_slt_grant: got %b exp 10", out_req_ready); end
        tick();
        checks++; if (out_resp_data !== 32'd1) begin errors++; $display("FAIL cmp_slt: got %h exp 1", out_resp_data); end
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b011);
        mid();
        checks++; if (out_req_ready !== 2'b10) begin errors++; $display("FAIL cmp_sltu_grant: got %b exp 10", out_req_ready); end
        tick();
        checks++; if (out_resp_data !== 32'd0) begin errors++; $display("FAIL cmp_sltu: got %h exp 0", out_resp_data); end
        checks++; if (out_resp_valid !== 2'b10) begin errors++; $display("FAIL cmp_sltu_valid: got %b exp 10", out_resp_valid); end
        // Pointer wrapped to 0: with both pending, req0 wins then req1.
        set_req(0, 32'd1, 32'd32, 3'b001);
        set_req(1, 32'hF0F0_F0F0, 32'd4, 3'b101);
        in_req_valid = 2'b11;
        mid();
        checks++; if (out_req_ready !== 2'b01) begin errors++; $display("FAIL cmp_wrap_grant: got %b exp 01", out_req_ready); end
        tick();
        in_req_valid = 2'b10;
        checks++; if (out_resp_data !== 32'd0) begin errors++; $display("FAIL cmp_sll32: got %h exp 0", out_resp_data); end
        mid();
        checks++; if (out_req_ready !== 2'b10) begin errors++; $display("FAIL cmp_next_grant: got %b exp 10", out_req_ready); end
        tick();
        in_req_valid = 2'b00;
        checks++; if (out_resp_data !== 32'h0F0F_0F0F) begin errors++; $display("FAIL cmp_srl: got %h exp 0f0f0f0f", out_resp_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] own;
        for (int o = 1; o >= 0; o--) begin
            do_reset();
            own = (o == 1) ? 2'b10 : 2'b01;
            set_req(0, 32'd2, 32'd3, 3'b110);
            set_req(1, 32'd2, 32'd3, 3'b110);
            in_req_valid  = own;
            in_resp_ready = 2'b00;
            tick();
            checks++; if (out_resp_valid !== own) begin errors++; $display("FAIL rm_full%0d: got %b exp %b", o, out_resp_valid, own); end
            reset        = 1'b1;
            in_req_valid = 2'b11;
            mid();
            checks++; if (out_req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready_in_reset%0d: got %b exp 00", o, out_req_ready); end
            tick();
            reset = 1'b0;
            checks++; if (out_resp_valid !== 2'b00) begin errors++; $display("FAIL rm_valid%0d: got %b exp 00", o, out_resp_valid); end
            checks++; if (out_resp_data !== 32'd0) begin errors++; $display("FAIL rm_data%0d: got %h exp 0", o, out_resp_data); end
            checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL rm_busy%0d: got %b exp 0", o, out_busy); end
            mid();
            checks++; if (out_req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant%0d: got %b exp 01", o, out_req_ready); end
            tick();
            in_req_valid = 2'b00;
        end
    endtask

    task automatic test_nonowner_ready();
        do_reset();
        set_req(0, 32'h1234_5678, 32'h0000_FFFF, 3'b111);
        in_req_valid  = 2'b01;
        in_resp_ready = 2'b10;
        tick();
        set_req(1, 32'd1, 32'd1, 3'b000);
        in_req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            mid();
            checks++; if (out_req_ready !== 2'b00) begin errors++; $display("FAIL no_ready%0d: got %b exp 00", k, out_req_ready); end
            tick();
            checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL no_busy%0d: got %b exp 1", k, out_busy); end
            checks++; if (out_resp_data !== 32'h0000_5678) begin errors++; $display("FAIL no_data%0d: got %h exp 00005678", k, out_resp_data); end
            checks++; if (out_resp_valid !== 2'b01) begin errors++; $display("FAIL no_valid%0d: got %b exp 01", k, out_resp_valid); end
        end
        in_resp_ready = 2'b11;
        tick();
        in_req_valid = 2'b00;
        checks++; if (out_resp_data !== 32'd2) begin errors++; $display("FAIL no_release_data: got %h exp 2", out_resp_data); end
        checks++; if (out_resp_valid !== 2'b10) begin errors++; $display("FAIL no_release_valid: got %b exp 10", out_resp_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_compare_wrap();
        test_reset_mid();
        test_nonowner_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
